rs_latch_ctrl: RTL and testbench
================================

Name: rs_latch_ctrl

Overview:
- Sequencer/arbiter that shares one external cross-coupled NOR RS latch (status flag) among NREQ requesters.
- Grants one requester at a time, round-robin, and drives a set or clear pulse of guaranteed width. Never asserts S and R together.
- Waits for the latch to settle, then reads back Q/Q_L through a synchronizer and reports done or error.
- Sits between the lab's clocked control logic and the gate-level latch.

Parameters:
- NREQ, 2, number of requesters (2..8).
- PULSE_CYC, 2, cycles S or R is held high (>=1).
- SETTLE_CYC, 1, idle cycles after the pulse before sampling begins (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- req_set  input  NREQ  per-requester request to set the latch; held until done.
- req_clr  input  NREQ  per-requester request to clear the latch; held until done.
- grant  output  NREQ  one-hot; identifies the requester being serviced.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse in CHECK; coincides with grant.
- err  output  1  one-cycle pulse with done when the readback check fails.
- flag  output  1  controller's registered copy of the last successfully written latch value.
- latch_S  output  1  drives the latch S input.
- latch_R  output  1  drives the latch R input.
- latch_Q  input  1  latch Q; asynchronous to clk.
- latch_Q_L  input  1  latch Q_L; asynchronous to clk.

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE, rr pointer=0, grant=0, busy=0, done=0, err=0, flag=0, latch_S=0, latch_R=0, synchronizer flops=0. Takes effect mid-operation: an S/R pulse drops immediately.
- Registered outputs only; S and R come straight from flops.
- Valid request: req_set[i] XOR req_clr[i]. If both are high for the same i, the request is masked, never granted, and produces no err.
- Arbitration: in IDLE, choose the first valid requester at or after the pointer, wrapping modulo NREQ.
  - Pointer := winner+1, mod NREQ, on grant.
  - The kind (set or clear) is latched at grant time. Later changes to req are ignored until IDLE.
- FSM:
  - IDLE: valid request seen in cycle N -> PULSE at N+1 with grant, busy, and (latch_S if set, else latch_R) registered high.
  - PULSE: hold for PULSE_CYC cycles -> SETTLE. S and R both return low on exit.
  - SETTLE: hold for SETTLE_CYC+2 cycles (the +2 covers the 2-flop synchronizers on Q and Q_L) -> CHECK.
  - CHECK: 1 cycle. done=1, grant still asserted.
    - Pass: syncQ==expected and syncQ_L==!expected. flag:=expected and err=0.
    - Fail: any other readback. err=1 and flag unchanged.
    - -> IDLE.
- Latency: done asserts at N+1+PULSE_CYC+SETTLE_CYC+2, which is N+6 at defaults.
- Requester handshake: drop req in the cycle after done. A req still held is re-arbitrated and competes at the new pointer position.
- Invariants:
  - latch_S & latch_R == 0 always.
  - grant is one-hot or zero.
  - grant!=0 iff busy.
- No-op writes (setting an already-set latch) are still pulsed and checked.

Decomposition:
- Shared package rs_ctrl_pkg:
  - state enum IDLE/PULSE/SETTLE/CHECK.
  - SYNC_STAGES=2 constant.
  - OP_SET/OP_CLR encoding.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin select with pointer, masked-request input, one-hot output).
- The synchronizer stays inline.

Test Plan:
- Reset: hold reset_L=0 for 3 cycles -> all outputs 0. Release, no requests -> busy stays 0.
- Single set: req_set=01 at cycle N, RS latch model with #5 -> latch_S=1 at N+1..N+2, done=1 and err=0 at N+6, flag=1, grant=01 for N+1..N+6.
- Contention: req_set=01 and req_clr=10 at N, pointer 0 -> requester 0 sets (done N+6). Requester 1 is granted at N+8 and clears, with latch_R high N+8..N+9 and done N+13, flag=0. latch_S&latch_R never both 1.
- Fault: force latch_Q stuck at 0 during a set -> done and err pulse together at N+6, flag stays 0.
- Conflict mask: req_set=01 and req_clr=01 held for 10 cycles -> grant stays 0, no S/R activity.
- Reset mid-PULSE: reset_L low at N+2 -> latch_S falls in the same timestep, state IDLE, no done. After release, a held req restarts cleanly.

Source files
------------

// File: rtl/rs_ctrl_pkg.sv
// Shared types and constants for the RS latch controller: FSM states, op kind
// encoding and the readback synchronizer depth.
package rs_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_e;
  typedef enum logic {OP_CLR = 1'b0, OP_SET = 1'b1} op_e;

  localparam int SYNC_STAGES = 2;

  // Longest phase the shared phase counter has to cover.
  function automatic int cnt_max(int pulse_cyc, int settle_cyc);
    return (pulse_cyc > settle_cyc + SYNC_STAGES) ? pulse_cyc : settle_cyc + SYNC_STAGES;
  endfunction

  // Round-robin search index: k-th candidate starting at the pointer.
  function automatic int rr_idx(int ptr, int k, int n);
    return (ptr + k) % n;
  endfunction
endpackage

// File: rtl/rs_latch_ctrl_if.sv
// Requester handshake plus latch pin bundle; master = requesters/latch side,
// slave = controller.
interface rs_latch_ctrl_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_set, req_clr, grant;
  logic busy, done, err, flag;
  logic latch_S, latch_R, latch_Q, latch_Q_L;

  modport master (output req_set, req_clr, latch_Q, latch_Q_L,
                  input  grant, busy, done, err, flag, latch_S, latch_R);
  modport slave  (input  req_set, req_clr, latch_Q, latch_Q_L,
                  output grant, busy, done, err, flag, latch_S, latch_R);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot select; pointer moves to winner+1 when adv is pulsed.
module rr_arbiter
  import rs_ctrl_pkg::*;
#(parameter int NREQ = 2)
(
  input  logic            clk,
  input  logic            reset_L,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic            any
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr, win;

  always_comb begin
    gnt = '0;
    win = ptr;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[rr_idx(int'(ptr), k, NREQ)]) begin
        any = 1'b1;
        gnt[rr_idx(int'(ptr), k, NREQ)] = 1'b1;
        win = PW'(rr_idx(int'(ptr), k, NREQ));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      ptr <= '0;
    else if (adv)
      ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
  end
endmodule

// File: rtl/rs_latch_ctrl.sv
// Shares one external NOR RS latch among NREQ requesters: arbitrates, pulses
// S or R for a fixed width, waits out settle + synchronizer, then checks Q/Q_L.
module rs_latch_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
)
(
  input logic             clk,
  input logic             reset_L,
  rs_latch_ctrl_if.slave  bus
);
  localparam int SETTLE_LEN = SETTLE_CYC + SYNC_STAGES;
  localparam int CW         = $clog2(cnt_max(PULSE_CYC, SETTLE_CYC));

  state_e          state, state_n;
  op_e             kind, kind_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] grant, grant_n, vld, arb_gnt;
  logic            busy, busy_n, done, done_n, err, err_n, flag, flag_n;
  logic            lat_s, lat_s_n, lat_r, lat_r_n;
  logic            arb_any, adv, is_set, exp_v, pass;
  logic [SYNC_STAGES-1:0] q_sh, ql_sh;

  // A requester asserting both set and clear is masked out entirely.
  assign vld    = bus.req_set ^ bus.req_clr;
  assign is_set = |(bus.req_set & arb_gnt);
  assign exp_v  = (kind == OP_SET);
  assign pass   = (q_sh[SYNC_STAGES-1] == exp_v) && (ql_sh[SYNC_STAGES-1] == !exp_v);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk), .reset_L(reset_L), .req(vld), .adv(adv), .gnt(arb_gnt), .any(arb_any)
  );

  always_comb begin
    state_n = state;
    kind_n  = kind;
    cnt_n   = cnt;
    grant_n = grant;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    flag_n  = flag;
    lat_s_n = lat_s;
    lat_r_n = lat_r;
    adv     = 1'b0;
    case (state)
      IDLE: if (arb_any) begin
        state_n = PULSE;
        adv     = 1'b1;
        grant_n = arb_gnt;
        busy_n  = 1'b1;
        kind_n  = is_set ? OP_SET : OP_CLR;
        lat_s_n = is_set;
        lat_r_n = !is_set;
        cnt_n   = '0;
      end
      PULSE: if (cnt == CW'(PULSE_CYC - 1)) begin
        state_n = SETTLE;
        lat_s_n = 1'b0;
        lat_r_n = 1'b0;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      // Last settle cycle: synchronized readback is judged here so done/err
      // and the new flag appear together in CHECK.
      SETTLE: if (cnt == CW'(SETTLE_LEN - 1)) begin
        state_n = CHECK;
        done_n  = 1'b1;
        err_n   = !pass;
        if (pass) flag_n = exp_v;
      end else cnt_n = cnt + CW'(1);
      CHECK: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      kind  <= OP_CLR;
      cnt   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      flag  <= 1'b0;
      lat_s <= 1'b0;
      lat_r <= 1'b0;
      q_sh  <= '0;
      ql_sh <= '0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      cnt   <= cnt_n;
      grant <= grant_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
      flag  <= flag_n;
      lat_s <= lat_s_n;
      lat_r <= lat_r_n;
      q_sh  <= {q_sh[SYNC_STAGES-2:0], bus.latch_Q};
      ql_sh <= {ql_sh[SYNC_STAGES-2:0], bus.latch_Q_L};
    end
  end

  assign bus.grant   = grant;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.flag    = flag;
  assign bus.latch_S = lat_s;
  assign bus.latch_R = lat_r;
endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Bench for rs_latch_ctrl: behavioural RS latch, vector table with scoreboard,
// and hand sequences for contention, masking and reset during a pulse.
module tb_rs_latch_ctrl;
  localparam int NREQ = 2, PULSE_CYC = 2, SETTLE_CYC = 1;
  localparam int LAT  = 1 + PULSE_CYC + SETTLE_CYC + 2;

  logic clk = 1'b0, reset_L = 1'b0, stuck = 1'b0, mq = 1'b0;
  int   n_vec = 0, n_err = 0;

  rs_latch_ctrl_if #(.NREQ(NREQ)) bus();
  rs_latch_ctrl #(.NREQ(NREQ), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  always #5 clk = ~clk;

  // Latch model with 5ns response; stuck forces Q low while Q_L tracks the cell.
  always @(bus.latch_S or bus.latch_R) begin
    if (bus.latch_S && !bus.latch_R)      mq <= #5 1'b1;
    else if (bus.latch_R && !bus.latch_S) mq <= #5 1'b0;
  end
  assign bus.latch_Q   = stuck ? 1'b0 : mq;
  assign bus.latch_Q_L = ~mq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) if (reset_L) begin
    check("inv_sr", 32'(bus.latch_S & bus.latch_R), 0);
    check("inv_onehot", 32'($onehot0(bus.grant)), 1);
    check("inv_busy", 32'(bus.grant != '0), 32'(bus.busy));
  end

  typedef struct {
    logic [NREQ-1:0] set, clr;
    logic            stk;
    logic [NREQ-1:0] g;
    logic            is_set, e, f;
  } vec_t;

  vec_t tbl[9];
  vec_t sb[$];

  task automatic run_vec(input vec_t v, input string tag);
    vec_t x;
    int   n = 0, sc = 0, rc = 0;
    bit   seen = 0;
    bus.req_set = v.set; bus.req_clr = v.clr; stuck = v.stk;
    sb.push_back(v);
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      sc += int'(bus.latch_S); rc += int'(bus.latch_R);
      if (bus.done) seen = 1;
    end
    x = sb.pop_front();
    check({tag, "_done"}, 32'(seen), 1);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_grant"}, 32'(bus.grant), 32'(x.g));
    check({tag, "_err"}, 32'(bus.err), 32'(x.e));
    check({tag, "_flag"}, 32'(bus.flag), 32'(x.f));
    check({tag, "_scnt"}, sc, x.is_set ? PULSE_CYC : 0);
    check({tag, "_rcnt"}, rc, x.is_set ? 0 : PULSE_CYC);
    @(negedge clk);
    bus.req_set = '0; bus.req_clr = '0; stuck = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int d1, d2, bad;
    //            set    clr    stk   grant  set  err  flag
    tbl[0] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{2'b00, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{2'b10, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0}; // ptr 0 favours req 0
    tbl[4] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1}; // no-op write
    tbl[6] = '{2'b00, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0}; // Q stuck low
    tbl[8] = '{2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1}; // req 0 masked

    bus.req_set = '0; bus.req_clr = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({bus.grant, bus.busy, bus.done, bus.err, bus.flag, bus.latch_S, bus.latch_R}), 0);
    reset_L = 1'b1;
    bad = 0;
    repeat (4) begin @(negedge clk); bad += int'(bus.busy); end
    check("rst_idle_busy", bad, 0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Contention: req0 set and req1 clear together with pointer at 0.
    bus.req_set = 2'b01; bus.req_clr = 2'b10;
    d1 = 0; d2 = 0; bad = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (bus.done && d1 == 0) d1 = n; else if (bus.done) d2 = n;
      if (n == 6) check("cont_flag1", 32'(bus.flag), 1);
      if (n == 7) bus.req_set = '0;
      if (n == 8) check("cont_grant1", 32'(bus.grant), 32'(2'b10));
      if (n == 8 || n == 9) bad += int'(!bus.latch_R);
      if (n == 10) bad += int'(bus.latch_R);
      if (n == 14) bus.req_clr = '0;
    end
    check("cont_done0", d1, LAT);
    check("cont_done1", d2, LAT + 7);
    check("cont_rpulse", bad, 0);
    check("cont_flag0", 32'(bus.flag), 0);

    // Both set and clear from one requester: never serviced.
    bus.req_set = 2'b01; bus.req_clr = 2'b01; bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += int'(bus.grant != '0) + int'(bus.latch_S | bus.latch_R) + int'(bus.err);
    end
    check("mask_quiet", bad, 0);
    bus.req_set = '0; bus.req_clr = '0;
    @(negedge clk);

    // Reset during PULSE drops S at once; held request then restarts.
    bus.req_set = 2'b01;
    @(negedge clk);
    check("mid_s_up", 32'(bus.latch_S), 1);
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    check("mid_rst_outs", 32'({bus.grant, bus.busy, bus.done, bus.latch_S, bus.latch_R}), 0);
    @(negedge clk);
    reset_L = 1'b1;
    d1 = 0;
    for (int n = 1; n <= 12 && d1 == 0; n++) begin
      @(negedge clk);
      if (bus.done) d1 = n;
    end
    check("mid_restart_lat", d1, LAT);
    check("mid_restart_err", 32'(bus.err), 0);
    check("mid_restart_flag", 32'(bus.flag), 1);
    bus.req_set = '0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
